shift_stage: RTL and testbench

SHIFT_STAGE -- requirements
Module: shift_stage

---
 rtl/shift_pkg.sv | 24 ++
 rtl/shift_core.sv | 51 +++++
 rtl/shift_stage.sv | 104 ++++++++++
 tb/tb_shift_stage.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift stage: data widths, op encodings and the
// request record held in the input FIFO.
package shift_pkg;

    localparam int DATA_W  = 16;
    localparam int SHAMT_W = 4;
    localparam int OPCNT_W = 16;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRA = 2'b01,
        OP_ROR = 2'b10,
        OP_SRL = 2'b11
    } shift_op_e;

    typedef logic [DATA_W-1:0] word_t;

    typedef struct packed {
        shift_op_e            op;
        word_t                data;
        logic [SHAMT_W-1:0]   shamt;
    } shift_req_t;

endpackage

// File: rtl/shift_core.sv
// Combinational 16-bit shifter: a 1/2/4/8 log cascade for left shifts and a
// matching cascade for SRA/SRL/ROR right shifts.
module shift_core
    import shift_pkg::*;
(
    input  shift_op_e          op,
    input  word_t              data,
    input  logic [SHAMT_W-1:0] shamt,
    output word_t              result
);

    // One fixed-distance right stage; the fill source depends on the op.
    function automatic word_t right_step(input word_t v, input shift_op_e kind,
                                         input int unsigned amt);
        word_t r;
        case (kind)
            OP_SRA:  r = word_t'($signed(v) >>> amt);
            OP_ROR:  r = (v >> amt) | (v << (DATA_W - amt));
            default: r = v >> amt;
        endcase
        return r;
    endfunction

    word_t l_acc;
    word_t r_acc;

    always_comb begin
        // NOTE: every variable gets a value before any condition, so no latch is inferred.
        l_acc  = data;
        r_acc  = data;
        // NOTE: blocking '=' is deliberate in combinational logic; each stage reads the previous stage's value.
        if (shamt[0]) begin
            l_acc = l_acc << 1;
            r_acc = right_step(r_acc, op, 1);
        end
        if (shamt[1]) begin
            l_acc = l_acc << 2;
            r_acc = right_step(r_acc, op, 2);
        end
        if (shamt[2]) begin
            l_acc = l_acc << 4;
            r_acc = right_step(r_acc, op, 4);
        end
        if (shamt[3]) begin
            l_acc = l_acc << 8;
            r_acc = right_step(r_acc, op, 8);
        end
        result = (op == OP_SLL) ? l_acc : r_acc;
    end

endmodule

// File: rtl/shift_stage.sv
// Pipelined shift stage: input FIFO, registered result with valid/ready
// handshake, flush, and a count of completed output handshakes.
module shift_stage
    import shift_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [OPCNT_W-1:0] op_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    shift_req_t       fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_next;

    shift_req_t in_req;
    shift_req_t head_req;
    word_t      head_result;
    logic       push;
    logic       pop;
    logic       head_valid;
    logic       out_fire;

    assign in_req     = '{op: shift_op_e'(in_op), data: in_data, shamt: in_shamt};
    assign head_req   = fifo_mem[rd_ptr];
    assign head_valid = (occ != '0);

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready = (occ < OCC_FULL);
    assign out_fire = out_valid && out_ready;
    assign push     = in_valid && in_ready && !flush;
    assign pop      = head_valid && (!out_valid || out_ready) && !flush;

    shift_core u_core (
        .op     (head_req.op),
        .data   (head_req.data),
        .shamt  (head_req.shamt),
        .result (head_result)
    );

    always_comb begin
        occ_next = occ;
        case ({push, pop})
            2'b10:   occ_next = occ + OCC_W'(1);
            2'b01:   occ_next = occ - OCC_W'(1);
            default: occ_next = occ;
        endcase
    end

    // NOTE: FIFO storage is not reset; occupancy and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_req;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            op_cnt    <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            out_valid <= 1'b0;
        end else begin
            occ <= occ_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                out_valid <= 1'b1;
                out_data  <= head_result;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
            if (out_fire) begin
                op_cnt <= op_cnt + OPCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_shift_stage.sv
// Directed bench for shift_stage: reset, shift ops, backpressure, flush,
// op_cnt wrap and mid-stream reset.
module tb_shift_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_data;
    logic [3:0]  in_shamt;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [15:0] op_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_cnt  = 16'h0000;

    always #5 clk = ~clk;

    shift_stage #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .op_cnt    (op_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_data = 16'h0000;
        in_shamt = 4'h0; flush = 1'b0; out_ready = 1'b0;
        step(); step();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || op_cnt !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b out_data=%h op_cnt=%h, want 0/0000/0000",
                     out_valid, out_data, op_cnt);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    // One isolated request with out_ready held high: checks latency, result and op_cnt.
    task automatic do_op(input logic [1:0] op, input logic [15:0] d, input logic [3:0] s,
                         input logic [15:0] want, input string name);
        int t = 0;
        out_ready = 1'b1;
        while (!in_ready && t < 20) begin
            step();
            t++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready_timeout: in_ready=%b want 1", name, in_ready);
        end
        in_valid = 1'b1; in_op = op; in_data = d; in_shamt = s;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_latency: out_valid=%b one edge after accept, want 0", name, out_valid);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== want) begin
            n_fail++;
            $display("FAIL %s_result: out_valid=%b out_data=%h want 1/%h", name, out_valid, out_data, want);
        end
        step();
        exp_cnt++;
        n_checks++;
        if (op_cnt !== exp_cnt || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_op_cnt: op_cnt=%h out_valid=%b want %h/0", name, op_cnt, out_valid, exp_cnt);
        end
    endtask

    task automatic test_sll();
        do_op(2'b00, 16'h00F1, 4'd4, 16'h0F10, "sll_basic");
        n_checks++;
        if (op_cnt !== 16'h0001) begin
            n_fail++;
            $display("FAIL sll_first_count: op_cnt=%h want 0001", op_cnt);
        end
    endtask

    task automatic test_shift_ops();
        logic [1:0]  ops  [15] = '{2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11,
                                   2'b00, 2'b11, 2'b01, 2'b10, 2'b10, 2'b00, 2'b01};
        logic [15:0] din  [15] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h0001, 16'h1234, 16'h1234,
                                   16'h1234, 16'h1234, 16'h8001, 16'h8001, 16'h8001, 16'h8001,
                                   16'h1234, 16'hABCD, 16'hA5A5};
        logic [3:0]  sh   [15] = '{4'd15, 4'd3, 4'd15, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0,
                                   4'd1, 4'd1, 4'd1, 4'd1, 4'd4, 4'd8, 4'd7};
        logic [15:0] want [15] = '{16'hFFFF, 16'h0FFF, 16'h0001, 16'h8000, 16'h1234, 16'h1234,
                                   16'h1234, 16'h1234, 16'h0002, 16'h4000, 16'hC000, 16'hC000,
                                   16'h4123, 16'hCD00, 16'hFF4B};
        for (int i = 0; i < 15; i++) begin
            do_op(ops[i], din[i], sh[i], want[i], $sformatf("vec%0d", i));
        end
        do_op(2'b11, 16'hA5A5, 4'd7, 16'h014B, "srl_a5a5");
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops  [4] = '{2'b00, 2'b11, 2'b10, 2'b01};
        logic [15:0] din  [4] = '{16'h0001, 16'h0100, 16'h000F, 16'h8000};
        logic [3:0]  sh   [4] = '{4'd1, 4'd4, 4'd4, 4'd1};
        logic [15:0] want [4] = '{16'h0002, 16'h0010, 16'hF000, 16'hC000};
        logic [15:0] res  [4];
        int acc = 0;
        int got = 0;
        logic was_ready;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_op = ops[acc]; in_data = din[acc]; in_shamt = sh[acc];
            was_ready = in_ready;
            step();
            if (was_ready) acc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (acc !== 3 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept_count: accepted=%0d in_ready=%b want 3/0", acc, in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== want[0]) begin
                n_fail++;
                $display("FAIL b2b_hold: out_valid=%b out_data=%h want 1/%h", out_valid, out_data, want[0]);
            end
            step();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (acc < 4) begin
                in_valid = 1'b1; in_op = ops[acc]; in_data = din[acc]; in_shamt = sh[acc];
            end else begin
                in_valid = 1'b0;
            end
            was_ready = in_ready && in_valid;
            if (out_valid) begin
                res[got] = out_data;
                got++;
            end
            step();
            if (was_ready) acc++;
        end
        in_valid = 1'b0;
        exp_cnt += 16'(got);
        n_checks++;
        if (got !== 4 || acc !== 4) begin
            n_fail++;
            $display("FAIL b2b_drain: results=%0d accepted=%0d want 4/4", got, acc);
        end
        for (int i = 0; i < got; i++) begin
            n_checks++;
            if (res[i] !== want[i]) begin
                n_fail++;
                $display("FAIL b2b_order[%0d]: got %h want %h", i, res[i], want[i]);
            end
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || op_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL b2b_after: out_valid=%b op_cnt=%h want 0/%h", out_valid, op_cnt, exp_cnt);
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_op = 2'b00; in_data = 16'h0011 + 16'(c); in_shamt = 4'd2;
            step();
        end
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_setup: out_valid=%b in_ready=%b want 1/0", out_valid, in_ready);
        end
        flush = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL flush_state: out_valid=%b in_ready=%b op_cnt=%h want 0/1/%h",
                     out_valid, in_ready, op_cnt, exp_cnt);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0 || op_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL flush_no_output: valid cycles=%0d op_cnt=%h want 0/%h", seen, op_cnt, exp_cnt);
        end
        do_op(2'b10, 16'h1234, 4'd4, 16'h4123, "post_flush");
    endtask

    task automatic test_count_wrap_and_reset();
        logic [15:0] q[$];
        logic [15:0] seq = 16'h0000;
        int bad = 0;
        int seen = 0;
        logic was_ready;
        logic hs;
        out_ready = 1'b1; in_op = 2'b00; in_shamt = 4'd0; in_valid = 1'b1;
        for (int c = 0; c < 70000 && exp_cnt != 16'hFFFF; c++) begin
            in_data = seq;
            was_ready = in_ready;
            hs = out_valid;
            if (hs) begin
                if (q.size() == 0) bad++;
                else if (out_data !== q[0]) bad++;
                if (q.size() != 0) void'(q.pop_front());
            end
            step();
            if (was_ready) begin
                q.push_back(seq);
                seq++;
            end
            if (hs) exp_cnt++;
        end
        n_checks++;
        if (exp_cnt !== 16'hFFFF || op_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL cnt_reach_ffff: handshakes->%h op_cnt=%h want FFFF/FFFF", exp_cnt, op_cnt);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL stream_order: %0d out-of-order or spurious results, want 0", bad);
        end
        hs = out_valid;
        in_data = seq;
        step();
        n_checks++;
        if (hs !== 1'b1 || op_cnt !== 16'h0000) begin
            n_fail++;
            $display("FAIL cnt_wrap: handshake=%b op_cnt=%h want 1/0000", hs, op_cnt);
        end
        rst_n = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || op_cnt !== 16'h0000 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midstream_reset: out_valid=%b out_data=%h op_cnt=%h in_ready=%b want 0/0000/0000/1",
                     out_valid, out_data, op_cnt, in_ready);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0 || op_cnt !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_discard: valid cycles=%0d op_cnt=%h want 0/0000", seen, op_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_sll();
        test_shift_ops();
        test_back_to_back();
        test_flush();
        test_count_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
